// File: rtl/edge_pkg.sv
// Shared encodings for the multi-channel edge detector.
// Holds channel FSM states, edge-select modes and the counter-width helper.
package edge_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic int cnt_width(input int db);
        return (db <= 2) ? 1 : $clog2(db);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, debounce FSM with counter, registered tick.
// tick_nxt is exposed so the top can register any_tick in step with tick.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic [1:0] mode,
    output logic       level_out,
    output logic       tick,
    output logic       tick_nxt
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic s;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign s = level;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] ff;
        always_ff @(posedge clk) begin
            if (reset) begin
                ff <= '0;
            end else begin
                ff[0] <= level;
                for (int i = 1; i < SYNC_STAGES; i++)
                    ff[i] <= ff[i-1];
            end
        end
        assign s = ff[SYNC_STAGES-1];
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise, fall;
    logic             level_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise      = 1'b0;
        fall      = 1'b0;
        case (state)
            ZERO: begin
                if (s) begin
                    if (DB_CYCLES == 1) begin
                        state_nxt = ONE;
                        rise      = 1'b1;
                    end else begin
                        state_nxt = WAIT1;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_nxt = ZERO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ONE;
                    cnt_nxt   = '0;
                    rise      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ONE: begin
                if (!s) begin
                    if (DB_CYCLES == 1) begin
                        state_nxt = ZERO;
                        fall      = 1'b1;
                    end else begin
                        state_nxt = WAIT0;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            WAIT0: begin
                if (s) begin
                    state_nxt = ONE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ZERO;
                    cnt_nxt   = '0;
                    fall      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ZERO;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level_nxt = (state_nxt == ONE) || (state_nxt == WAIT0);
    assign tick_nxt  =
        (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
        (fall && (mode == MODE_FALL || mode == MODE_BOTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ZERO;
            cnt       <= '0;
            level_out <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            tick      <= tick_nxt;
        end
    end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel debounced edge detector with per-channel edge select.
// Optional sticky event flags when MULTI_EDGE_DETECT_STICKY_EN is defined.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   level_out,
    output logic [N_CH-1:0]   tick,
    output logic              any_tick
`ifdef MULTI_EDGE_DETECT_STICKY_EN
    ,
    output logic [N_CH-1:0]   sticky,
    input  logic [N_CH-1:0]   sticky_clr
`endif
);

    logic [N_CH-1:0] tick_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .level    (level[i]),
            .mode     (mode[2*i+1:2*i]),
            .level_out(level_out[i]),
            .tick     (tick[i]),
            .tick_nxt (tick_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            any_tick <= 1'b0;
        else
            any_tick <= |tick_nxt;
    end

`ifdef MULTI_EDGE_DETECT_STICKY_EN
    // Set rises together with tick and takes priority over a clear.
    always_ff @(posedge clk) begin
        if (reset)
            sticky <= '0;
        else
            sticky <= (sticky & ~sticky_clr) | tick_nxt;
    end
`endif

endmodule
